// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI4 write arbiter; one burst in flight on the shared master port.
// Define AXI_WR_ARB_RR_EN for round-robin arbitration, otherwise S0 has fixed priority.
module axi_wr_arbiter #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 128
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    // requester 0
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   S0_AXI_AWADDR,
    input  logic [7:0]                      S0_AXI_AWLEN,
    input  logic [2:0]                      S0_AXI_AWSIZE,
    input  logic [1:0]                      S0_AXI_AWBURST,
    input  logic                            S0_AXI_AWVALID,
    output logic                            S0_AXI_AWREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   S0_AXI_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] S0_AXI_WSTRB,
    input  logic                            S0_AXI_WLAST,
    input  logic                            S0_AXI_WVALID,
    output logic                            S0_AXI_WREADY,
    output logic [1:0]                      S0_AXI_BRESP,
    output logic                            S0_AXI_BVALID,
    input  logic                            S0_AXI_BREADY,
    // requester 1
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   S1_AXI_AWADDR,
    input  logic [7:0]                      S1_AXI_AWLEN,
    input  logic [2:0]                      S1_AXI_AWSIZE,
    input  logic [1:0]                      S1_AXI_AWBURST,
    input  logic                            S1_AXI_AWVALID,
    output logic                            S1_AXI_AWREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   S1_AXI_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] S1_AXI_WSTRB,
    input  logic                            S1_AXI_WLAST,
    input  logic                            S1_AXI_WVALID,
    output logic                            S1_AXI_WREADY,
    output logic [1:0]                      S1_AXI_BRESP,
    output logic                            S1_AXI_BVALID,
    input  logic                            S1_AXI_BREADY,
    // shared master port
    output logic                            M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [1:0]                      GRANT,
    output logic                            ARB_ERR
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                          r_state;
    logic                            r_sel;
    logic [7:0]                      r_beat;
    logic [1:0]                      r_grant;
    logic                            r_err;
    logic                            r_awvalid;
    logic                            r_awid;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
    logic [7:0]                      r_awlen;
    logic [2:0]                      r_awsize;
    logic [1:0]                      r_awburst;

    logic w_any_req, w_win, w_aw_take, w_in_data, w_in_resp, w_w_hs, w_b_hs;

    assign w_any_req = S0_AXI_AWVALID | S1_AXI_AWVALID;

`ifdef AXI_WR_ARB_RR_EN
    // r_rr_ptr names the requester that wins the next tie
    logic r_rr_ptr;
    assign w_win = (S0_AXI_AWVALID & S1_AXI_AWVALID) ? r_rr_ptr : S1_AXI_AWVALID;

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN)
            r_rr_ptr <= 1'b0;
        else if (w_aw_take)
            r_rr_ptr <= ~w_win;
    end
`else
    assign w_win = ~S0_AXI_AWVALID;
`endif

    // AWREADY is the grant itself, so it must be combinational and masked during reset
    assign w_aw_take      = M_AXI_ARESETN & (r_state == IDLE) & w_any_req;
    assign S0_AXI_AWREADY = w_aw_take & ~w_win;
    assign S1_AXI_AWREADY = w_aw_take & w_win;

    assign w_in_data = (r_state == DATA);
    assign w_in_resp = (r_state == RESP);

    assign M_AXI_WDATA    = r_sel ? S1_AXI_WDATA : S0_AXI_WDATA;
    assign M_AXI_WSTRB    = r_sel ? S1_AXI_WSTRB : S0_AXI_WSTRB;
    assign M_AXI_WLAST    = w_in_data & (r_sel ? S1_AXI_WLAST : S0_AXI_WLAST);
    assign M_AXI_WVALID   = w_in_data & (r_sel ? S1_AXI_WVALID : S0_AXI_WVALID);
    assign S0_AXI_WREADY  = w_in_data & ~r_sel & M_AXI_WREADY;
    assign S1_AXI_WREADY  = w_in_data & r_sel & M_AXI_WREADY;
    assign w_w_hs         = M_AXI_WVALID & M_AXI_WREADY;

    assign M_AXI_BREADY   = w_in_resp & (r_sel ? S1_AXI_BREADY : S0_AXI_BREADY);
    assign S0_AXI_BVALID  = w_in_resp & ~r_sel & M_AXI_BVALID;
    assign S1_AXI_BVALID  = w_in_resp & r_sel & M_AXI_BVALID;
    assign S0_AXI_BRESP   = M_AXI_BRESP;
    assign S1_AXI_BRESP   = M_AXI_BRESP;
    assign w_b_hs         = M_AXI_BVALID & M_AXI_BREADY;

    assign M_AXI_AWID     = r_awid;
    assign M_AXI_AWADDR   = r_awaddr;
    assign M_AXI_AWLEN    = r_awlen;
    assign M_AXI_AWSIZE   = r_awsize;
    assign M_AXI_AWBURST  = r_awburst;
    assign M_AXI_AWVALID  = r_awvalid;
    assign GRANT          = r_grant;
    assign ARB_ERR        = r_err;

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_state   <= IDLE;
            r_sel     <= 1'b0;
            r_beat    <= '0;
            r_grant   <= 2'b00;
            r_err     <= 1'b0;
            r_awvalid <= 1'b0;
            r_awid    <= 1'b0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any_req) begin
                    r_sel     <= w_win;
                    r_awid    <= w_win;
                    r_grant   <= w_win ? 2'b10 : 2'b01;
                    r_awaddr  <= w_win ? S1_AXI_AWADDR  : S0_AXI_AWADDR;
                    r_awlen   <= w_win ? S1_AXI_AWLEN   : S0_AXI_AWLEN;
                    r_awsize  <= w_win ? S1_AXI_AWSIZE  : S0_AXI_AWSIZE;
                    r_awburst <= w_win ? S1_AXI_AWBURST : S0_AXI_AWBURST;
                    r_awvalid <= 1'b1;
                    r_state   <= ADDR;
                end
                ADDR: if (M_AXI_AWREADY) begin
                    r_awvalid <= 1'b0;
                    r_beat    <= '0;
                    r_state   <= DATA;
                end
                // the beat count, not WLAST, closes the burst; a disagreeing WLAST is flagged
                DATA: if (w_w_hs) begin
                    if (r_beat == r_awlen) begin
                        r_state <= RESP;
                        if (!M_AXI_WLAST) r_err <= 1'b1;
                    end else begin
                        r_beat <= r_beat + 8'd1;
                        if (M_AXI_WLAST) r_err <= 1'b1;
                    end
                end
                RESP: if (w_b_hs) begin
                    r_grant <= 2'b00;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: acts as both requesters and as the downstream slave.
module tb_axi_wr_arbiter;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][AW-1:0] s_awaddr;
    logic [1:0][7:0]    s_awlen;
    logic [1:0][2:0]    s_awsize;
    logic [1:0][1:0]    s_awburst;
    logic [1:0]         s_awvalid;
    logic [1:0][DW-1:0] s_wdata;
    logic [1:0][SW-1:0] s_wstrb;
    logic [1:0]         s_wlast, s_wvalid, s_bready;
    wire  [1:0]         s_awready, s_wready, s_bvalid;
    wire  [1:0][1:0]    s_bresp;

    logic               m_awready, m_wready, m_bvalid;
    logic [1:0]         m_bresp;
    wire                m_awid, m_awvalid, m_wlast, m_wvalid, m_bready, arb_err;
    wire  [AW-1:0]      m_awaddr;
    wire  [7:0]         m_awlen;
    wire  [2:0]         m_awsize;
    wire  [1:0]         m_awburst, grant;
    wire  [DW-1:0]      m_wdata;
    wire  [SW-1:0]      m_wstrb;

    axi_wr_arbiter #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
        .S0_AXI_AWADDR(s_awaddr[0]), .S0_AXI_AWLEN(s_awlen[0]), .S0_AXI_AWSIZE(s_awsize[0]),
        .S0_AXI_AWBURST(s_awburst[0]), .S0_AXI_AWVALID(s_awvalid[0]), .S0_AXI_AWREADY(s_awready[0]),
        .S0_AXI_WDATA(s_wdata[0]), .S0_AXI_WSTRB(s_wstrb[0]), .S0_AXI_WLAST(s_wlast[0]),
        .S0_AXI_WVALID(s_wvalid[0]), .S0_AXI_WREADY(s_wready[0]),
        .S0_AXI_BRESP(s_bresp[0]), .S0_AXI_BVALID(s_bvalid[0]), .S0_AXI_BREADY(s_bready[0]),
        .S1_AXI_AWADDR(s_awaddr[1]), .S1_AXI_AWLEN(s_awlen[1]), .S1_AXI_AWSIZE(s_awsize[1]),
        .S1_AXI_AWBURST(s_awburst[1]), .S1_AXI_AWVALID(s_awvalid[1]), .S1_AXI_AWREADY(s_awready[1]),
        .S1_AXI_WDATA(s_wdata[1]), .S1_AXI_WSTRB(s_wstrb[1]), .S1_AXI_WLAST(s_wlast[1]),
        .S1_AXI_WVALID(s_wvalid[1]), .S1_AXI_WREADY(s_wready[1]),
        .S1_AXI_BRESP(s_bresp[1]), .S1_AXI_BVALID(s_bvalid[1]), .S1_AXI_BREADY(s_bready[1]),
        .M_AXI_AWID(m_awid), .M_AXI_AWADDR(m_awaddr), .M_AXI_AWLEN(m_awlen),
        .M_AXI_AWSIZE(m_awsize), .M_AXI_AWBURST(m_awburst), .M_AXI_AWVALID(m_awvalid),
        .M_AXI_AWREADY(m_awready),
        .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WLAST(m_wlast),
        .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
        .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready),
        .GRANT(grant), .ARB_ERR(arb_err)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   pend[2];
    logic exp_err = 1'b0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk(tag, 256'({s_awready, s_wready, s_bvalid, m_awvalid, m_awid, m_awaddr, m_awlen,
                       m_awsize, m_awburst, m_wvalid, m_wlast, m_bready, grant, arb_err}), 256'(0));
    endtask

    // One granted burst: wl_beat 0 means WLAST on the final beat; abort_at >= 0 resets mid-data.
    task automatic serve(input int exp_who, input int wl_beat, input int aw_dly, input bit tog,
                         input logic [1:0] resp, input int exp_wait, input int abort_at);
        int cyc, b, lb;
        bit got;
        logic wb, lst;
        logic [AW-1:0] a;
        logic [7:0] len;
        logic [2:0] sz;
        logic [1:0] bu;
        logic [DW-1:0] pat;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            chk("idle_outs", 256'({grant, m_awvalid, m_wvalid, m_bready, s_bvalid, s_wready}), 256'(0));
            if (s_awready != 2'b00) got = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        if (!got) begin chk("aw_timeout", 256'(1), 256'(0)); return; end
        chk("awready", 256'(s_awready), 256'(exp_who != 0 ? 2'b10 : 2'b01));
        if (exp_wait >= 0) chk("turnaround", 256'(cyc), 256'(exp_wait));
        wb  = s_awready[1];
        a   = s_awaddr[wb];
        len = s_awlen[wb];
        sz  = s_awsize[wb];
        bu  = s_awburst[wb];
        lb  = (wl_beat == 0) ? int'(len) + 1 : wl_beat;
        @(posedge clk); #1;
        pend[wb]--;
        if (pend[wb] == 0) s_awvalid[wb] = 1'b0;
        else s_awaddr[wb] = s_awaddr[wb] + 32'h100;
        for (int d = 0; d <= aw_dly; d++) begin
            m_awready = (d == aw_dly);
            @(negedge clk);
            chk("aw_fields", 256'({m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, grant}),
                256'({1'b1, wb, a, len, sz, bu, wb, ~wb}));
            @(posedge clk); #1;
        end
        m_awready = 1'b0;
        b = 0;
        cyc = 0;
        s_wvalid[wb] = 1'b1;
        while (b <= int'(len) && cyc < 600) begin
            if (b == abort_at) begin
                rstn = 1'b0;
                s_awvalid = 2'b00;
                pend = '{0, 0};
                @(posedge clk); #1;
                @(negedge clk);
                chk_rst("rst_mid");
                exp_err = 1'b0;
                rstn = 1'b1;
                s_wvalid = 2'b00;
                s_wlast = 2'b00;
                m_wready = 1'b0;
                return;
            end
            pat = {32'hA5A5_0000 | 32'(wb), 32'(b), a, 32'hDEAD_BEEF ^ 32'(b)};
            lst = (b + 1 == lb);
            s_wdata[wb] = pat;
            s_wlast[wb] = lst;
            m_wready = tog ? ~cyc[0] & 1'b0 | cyc[0] : 1'b1;
            @(negedge clk);
            chk("w_route", 256'({m_wvalid, m_wdata, m_wstrb, m_wlast, s_wready}),
                256'({1'b1, pat, s_wstrb[wb], lst, m_wready & wb, m_wready & ~wb}));
            if (m_wready) begin
                if (b == int'(len)) begin
                    if (!lst) exp_err = 1'b1;
                end else if (lst) exp_err = 1'b1;
                b++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (b <= int'(len)) begin chk("w_timeout", 256'(b), 256'(int'(len) + 1)); return; end
        // requester keeps offering data: nothing more may pass once the count is reached
        m_wready = 1'b1;
        @(negedge clk);
        chk("w_closed", 256'({m_wvalid, s_wready, arb_err}), 256'({1'b0, 2'b00, exp_err}));
        @(posedge clk); #1;
        s_wvalid = 2'b00;
        s_wlast = 2'b00;
        m_wready = 1'b0;
        m_bvalid = 1'b1;
        m_bresp = resp;
        s_bready[wb] = 1'b1;
        @(negedge clk);
        chk("b_route", 256'({s_bvalid, m_bready, s_bresp[wb]}), 256'({wb, ~wb, 1'b1, resp}));
        @(posedge clk); #1;
        m_bvalid = 1'b0;
        s_bready = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        s_awaddr = '0; s_awlen = '0; s_awvalid = '0; s_wdata = '0;
        s_wlast = '0; s_wvalid = '0; s_bready = '0;
        s_awsize = {3'd3, 3'd4};
        s_awburst = {2'b01, 2'b01};
        s_wstrb = {16'h00FF, 16'hFFFF};
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        pend = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_rst("rst_init");
        @(posedge clk); #1;
        rstn = 1'b1;

        // simultaneous requests, four bursts each
        s_awaddr[0] = 32'h2000_0000;
        s_awaddr[1] = 32'h3000_0000;
        s_awlen = {8'd1, 8'd1};
        pend = '{4, 4};
        s_awvalid = 2'b11;
        for (int k = 0; k < 8; k++) begin
`ifdef AXI_WR_ARB_RR_EN
            serve(k % 2, 0, 0, 1'b0, 2'b00, 0, -1);
`else
            serve((k < 4) ? 0 : 1, 0, 0, 1'b0, 2'b00, 0, -1);
`endif
        end

        // single 16-beat S0 burst, slave always ready
        s_awaddr[0] = 32'h1000_0000;
        s_awlen[0] = 8'd15;
        pend[0] = 1;
        s_awvalid[0] = 1'b1;
        serve(0, 0, 0, 1'b0, 2'b00, -1, -1);

        // S1 4-beat burst, AWREADY late by 5 cycles, WREADY toggling
        s_awaddr[1] = 32'h4000_0040;
        s_awlen[1] = 8'd3;
        pend[1] = 1;
        s_awvalid[1] = 1'b1;
        serve(1, 0, 5, 1'b1, 2'b01, -1, -1);

        // S0 8-beat burst with WLAST on beat 4
        s_awaddr[0] = 32'h1000_0800;
        s_awlen[0] = 8'd7;
        pend[0] = 1;
        s_awvalid[0] = 1'b1;
        serve(0, 4, 1, 1'b0, 2'b11, -1, -1);
        @(negedge clk);
        chk("err_sticky", 256'({arb_err, grant}), 256'({1'b1, 2'b00}));
        @(posedge clk); #1;

        // reset during beat 5 of 16, then a fresh single-beat S1 burst
        s_awaddr[0] = 32'h1000_1000;
        s_awlen[0] = 8'd15;
        pend[0] = 1;
        s_awvalid[0] = 1'b1;
        serve(0, 0, 0, 1'b0, 2'b00, -1, 4);
        @(posedge clk); #1;
        s_awaddr[1] = 32'h5000_0000;
        s_awlen[1] = 8'd0;
        pend[1] = 1;
        s_awvalid[1] = 1'b1;
        serve(1, 0, 2, 1'b0, 2'b10, -1, -1);
        @(negedge clk);
        chk("final_idle", 256'({grant, arb_err, s_bvalid, m_awvalid}), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 128, AXI data width; WSTRB width is C_M_AXI_DATA_WIDTH/8.
REQ-003 SHALL have port M_AXI_ACLK, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port M_AXI_ARESETN, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have ports Sn_AXI_AWADDR/AWLEN(8)/AWSIZE(3)/AWBURST(2)/AWVALID, inputs, and Sn_AXI_AWREADY, output, for n=0,1: requester write-address channels.
REQ-006 SHALL have ports Sn_AXI_WDATA/WSTRB/WLAST/WVALID, inputs, and Sn_AXI_WREADY, output, for n=0,1: requester write-data channels.
REQ-007 SHALL have ports Sn_AXI_BRESP(2)/BVALID, outputs, and Sn_AXI_BREADY, input, for n=0,1: requester response channels.
REQ-008 SHALL have ports M_AXI_AWID(1)/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID, outputs, and M_AXI_AWREADY, input: shared write-address channel.
REQ-009 SHALL have ports M_AXI_WDATA/WSTRB/WLAST/WVALID, outputs, and M_AXI_WREADY, input: shared write-data channel.
REQ-010 SHALL have ports M_AXI_BRESP(2)/BVALID, inputs, and M_AXI_BREADY, output: shared response channel.
REQ-011 SHALL have ports GRANT, output, 2, one-hot current owner, and ARB_ERR, output, 1, sticky WLAST-mismatch flag.

Function
REQ-012 SHALL implement FSM states IDLE, ADDR, DATA, RESP; exactly one burst outstanding at any time.
REQ-013 IDLE: on any Sn_AXI_AWVALID, SHALL latch winner's AW fields into output registers, set GRANT, assert M_AXI_AWVALID next cycle, go ADDR.
REQ-014 M_AXI_AWID SHALL equal granted requester index (0 or 1).
REQ-015 Sn_AXI_AWREADY SHALL be asserted for the winner only, exactly one cycle, in the cycle the AW fields are latched; loser sees AWREADY=0.
REQ-016 ADDR: M_AXI_AWVALID SHALL hold with stable fields until M_AXI_AWREADY; then go DATA.
REQ-017 DATA: W channel SHALL be combinationally routed: M_AXI_W* = winner's W*, winner's WREADY = M_AXI_WREADY; loser WREADY=0; M_AXI_WVALID=0 outside DATA.
REQ-018 DATA SHALL count beats; on the handshake of beat AWLEN+1 go RESP; if WLAST on that beat is 0, or WLAST=1 on an earlier beat, set ARB_ERR (burst still ends on count).
REQ-019 RESP: M_AXI_BREADY = winner's BREADY, winner's BVALID = M_AXI_BVALID, BRESP passed through; loser BVALID=0; on B handshake go IDLE, GRANT=00.
REQ-020 Requests arriving while not IDLE SHALL wait; requester AW signals are not sampled outside IDLE.
REQ-021 Minimum burst turnaround SHALL be: B handshake cycle, then IDLE one cycle, then next grant.

Reset
REQ-022 On M_AXI_ARESETN=0 at a clock edge: state IDLE, GRANT=00, ARB_ERR=0, beat counter 0, round-robin pointer 0, all VALID/READY outputs 0, M_AXI_AW* fields 0.
REQ-023 Reset mid-burst SHALL abandon the burst immediately; no completion of the AXI transaction is attempted.

Configuration
REQ-024 With macro AXI_WR_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; pointer updates on each grant.
REQ-025 Without AXI_WR_ARB_RR_EN, arbitration SHALL be fixed priority, S0 over S1; no pointer register exists.

Verification
REQ-026 Single S0 burst AWADDR=0x10000000 AWLEN=15, slave always ready -> one M_AXI AW with AWID=0, 16 W beats, WLAST on beat 16, S0 BVALID once, GRANT back to 00.
REQ-027 S0 and S1 assert AWVALID same cycle, 4 back-to-back bursts each, RR_EN defined -> grant order S0,S1,S0,S1,...; undefined -> all S0 bursts first.
REQ-028 S1 burst AWLEN=3 with M_AXI_WREADY toggling every cycle and AWREADY delayed 5 cycles -> AW fields stable while waiting, exactly 4 data beats, S0 WREADY never 1.
REQ-029 S0 burst AWLEN=7 with WLAST on beat 4 -> ARB_ERR=1 sticky, burst still ends after beat 8, RESP completes.
REQ-030 Reset asserted during DATA beat 5 of 16 -> next cycle all outputs at reset values; fresh S1 request afterwards granted normally.
